cbus_arbiter: RTL

CBUS_ARBITER -- requirements
Module: cbus_arbiter

---
 rtl/cbus_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/cbus_arbiter.sv
// Two-port CBus arbiter: merges instruction and data requests onto one downstream port.
// A grant is held from acceptance until the final ready&last beat of the transaction.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  ireq,
    output cbus_resp_t iresp,
    input  cbus_req_t  dreq,
    output cbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0] state;
    logic       grant;       // 0 = I, 1 = D
    logic       last_grant;
    logic       sel_d;

    // Reset value of last_grant (D) makes the first conflict go to I.
    always_comb begin
        sel_d = dreq.valid;
        if (ireq.valid && dreq.valid) begin
            sel_d = (ROUND_ROBIN != 0) ? ~last_grant : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ireq.valid || dreq.valid) begin
                        state <= BUSY;
                        grant <= sel_d;
                    end
                end
                BUSY: begin
                    if (oresp.ready && oresp.last) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data fans out to both ports; only the granted port sees ready/last.
    always_comb begin
        oreq        = '0;
        iresp       = '0;
        dresp       = '0;
        iresp.data  = oresp.data;
        dresp.data  = oresp.data;
        if (state == BUSY) begin
            if (grant) begin
                oreq        = dreq;
                dresp.ready = oresp.ready;
                dresp.last  = oresp.last;
            end else begin
                oreq        = ireq;
                iresp.ready = oresp.ready;
                iresp.last  = oresp.last;
            end
        end
    end
endmodule
